// File: rtl/palette_writer.sv
`default_nettype none
// palette_writer: streams 24-bit colours into the 512-entry palette RAM as a low-word then high-byte write.
// Optional macro PALWR_VBLANK_GATE_EN confines palette writes to cycles where registered vblank is high.
module palette_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  base,
  input  logic [9:0]  count,
  input  logic        abort,
  input  logic        vblank,
  input  logic        in_valid,
  input  logic [23:0] in_data,
  output logic        in_ready,
  output logic        pal_we,
  output logic [9:0]  pal_adr,
  output logic [15:0] pal_dat,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t      r_state;
  logic [8:0]  r_idx;
  logic [9:0]  r_rem;
  logic [23:0] r_col;
  logic [9:0]  r_adr_hold;
  logic [15:0] r_dat_hold;

  logic        w_gate;
  logic        w_wr_state;
  logic        w_we;
  logic [9:0]  w_adr;
  logic [15:0] w_dat;

`ifdef PALWR_VBLANK_GATE_EN
  logic r_vb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vb_q <= 1'b0;
    else     r_vb_q <= vblank;
  end

  assign w_gate = r_vb_q;
`else
  logic w_unused_vblank;

  assign w_unused_vblank = vblank;
  assign w_gate          = 1'b1;
`endif

  // Write strobe and bus are decoded from registered state only, never from live vblank.
  assign w_wr_state = (r_state == S_WR_LO) || (r_state == S_WR_HI);
  assign w_we       = w_wr_state && w_gate;
  assign w_adr      = {r_idx, (r_state == S_WR_HI)};
  assign w_dat      = (r_state == S_WR_HI) ? {8'h00, r_col[23:16]} : r_col[15:0];

  assign pal_we   = w_we;
  assign pal_adr  = w_we ? w_adr : r_adr_hold;
  assign pal_dat  = w_we ? w_dat : r_dat_hold;
  assign in_ready = (r_state == S_FETCH);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 9'd0;
      r_rem      <= 10'd0;
      r_col      <= 24'd0;
      r_adr_hold <= 10'd0;
      r_dat_hold <= 16'd0;
    end else begin
      if (w_we) begin
        r_adr_hold <= w_adr;
        r_dat_hold <= w_dat;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != 10'd0) begin
              r_idx   <= base;
              r_rem   <= count;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (in_valid) begin
            r_col   <= in_data;
            r_state <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (abort)       r_state <= S_IDLE;
          else if (w_gate) r_state <= S_WR_HI;
        end
        S_WR_HI: begin
          // A high-byte write coinciding with abort is still driven this cycle.
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_gate) begin
            r_idx   <= r_idx + 9'd1;
            r_rem   <= r_rem - 10'd1;
            r_state <= (r_rem == 10'd1) ? S_FIN : S_FETCH;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_palette_writer.sv
`default_nettype none
// tb_palette_writer: directed self-checking bench for palette_writer (gate test when PALWR_VBLANK_GATE_EN is set).
module tb_palette_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base;
  logic [9:0]  count;
  logic        abort;
  logic        vblank;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        pal_we;
  logic [9:0]  pal_adr;
  logic [15:0] pal_dat;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc    = 0;
  int done_cnt, done_cyc, ready_seen, we_in_fetch;
  logic [9:0]  wr_adr_q[$];
  logic [15:0] wr_dat_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc_q[$];

  palette_writer dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .abort(abort), .vblank(vblank), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pal_we(pal_we), .pal_adr(pal_adr), .pal_dat(pal_dat),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pal_we) begin
        wr_adr_q.push_back(pal_adr);
        wr_dat_q.push_back(pal_dat);
        wr_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (in_ready) ready_seen++;
      if (pal_we && in_ready) we_in_fetch++;
    end
  end

  task automatic clear_log();
    wr_adr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete(); acc_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; ready_seen = 0; we_in_fetch = 0;
  endtask

  task automatic start_cmd(input logic [8:0] b, input logic [9:0] c);
    @(posedge clk); #1;
    start = 1'b1; base = b; count = c;
    @(posedge clk);
    s_cyc = cyc;
    #1; start = 1'b0;
  endtask

  task automatic feed(input logic [23:0] d, input int gap);
    bit got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL feed_timeout: beat %h not accepted within 400 cycles", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b after 3000 cycles, required 0", nm, busy);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base = '0; count = '0; abort = 1'b0;
    vblank = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (pal_we !== 1'b0) begin n_fail++; $display("FAIL reset_pal_we: got %b want 0", pal_we); end
    n_checks++; if (pal_adr !== 10'h000) begin n_fail++; $display("FAIL reset_pal_adr: got %h want 000", pal_adr); end
    n_checks++; if (pal_dat !== 16'h0000) begin n_fail++; $display("FAIL reset_pal_dat: got %h want 0000", pal_dat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  // One entry with an immediate beat: two writes back-to-back, done the cycle after.
  task automatic test_single(input logic [8:0] b, input logic [23:0] d, input logic vb);
    clear_log();
    vblank = vb;
    start_cmd(b, 10'd1);
    feed(d, 0);
    wait_idle("single");
    vblank = 1'b1;
    n_checks++; if (wr_adr_q.size() !== 2) begin n_fail++; $display("FAIL single_nwrites: got %0d want 2", wr_adr_q.size()); end
    n_checks++; if (wr_adr_q[0] !== {b, 1'b0}) begin n_fail++; $display("FAIL single_adr_lo: got %h want %h", wr_adr_q[0], {b, 1'b0}); end
    n_checks++; if (wr_dat_q[0] !== d[15:0]) begin n_fail++; $display("FAIL single_dat_lo: got %h want %h", wr_dat_q[0], d[15:0]); end
    n_checks++; if (wr_adr_q[1] !== {b, 1'b1}) begin n_fail++; $display("FAIL single_adr_hi: got %h want %h", wr_adr_q[1], {b, 1'b1}); end
    n_checks++; if (wr_dat_q[1] !== {8'h00, d[23:16]}) begin n_fail++; $display("FAIL single_dat_hi: got %h want %h", wr_dat_q[1], {8'h00, d[23:16]}); end
    n_checks++; if (acc_cyc_q.size() !== 1 || acc_cyc_q[0] !== s_cyc + 1) begin n_fail++; $display("FAIL single_fetch_cycle: accepts=%0d at rel %0d, want 1 at rel 1", acc_cyc_q.size(), acc_cyc_q[0] - s_cyc); end
    n_checks++; if (wr_cyc_q[0] !== s_cyc + 2 || wr_cyc_q[1] !== s_cyc + 3) begin n_fail++; $display("FAIL single_write_cycles: got rel %0d,%0d want 2,3", wr_cyc_q[0] - s_cyc, wr_cyc_q[1] - s_cyc); end
    n_checks++; if (done_cnt !== 1 || done_cyc !== s_cyc + 4) begin n_fail++; $display("FAIL single_done: count %0d at rel %0d, want 1 at rel 4", done_cnt, done_cyc - s_cyc); end
  endtask

  task automatic test_wrap();
    logic [8:0]  idx;
    logic [23:0] beat;
    clear_log();
    start_cmd(9'd510, 10'd4);
    for (int k = 1; k <= 4; k++) begin
      beat = {8'hA0 + 8'(k), 16'h1000 + 16'(k)};
      feed(beat, 0);
      if (k == 1) begin
        start = 1'b1; base = 9'd0; count = 10'd1;
        @(posedge clk); #1; start = 1'b0;
      end
    end
    wait_idle("wrap");
    n_checks++; if (wr_adr_q.size() !== 8) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 8", wr_adr_q.size()); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
    for (int k = 0; k < 4; k++) begin
      idx = 9'(510 + k);
      n_checks++;
      if (wr_adr_q[2*k] !== {idx, 1'b0} || wr_dat_q[2*k] !== 16'h1001 + 16'(k)) begin
        n_fail++; $display("FAIL wrap_lo_%0d: got %h/%h want %h/%h", k, wr_adr_q[2*k], wr_dat_q[2*k], {idx, 1'b0}, 16'h1001 + 16'(k));
      end
      n_checks++;
      if (wr_adr_q[2*k+1] !== {idx, 1'b1} || wr_dat_q[2*k+1] !== {8'h00, 8'hA1 + 8'(k)}) begin
        n_fail++; $display("FAIL wrap_hi_%0d: got %h/%h want %h/%h", k, wr_adr_q[2*k+1], wr_dat_q[2*k+1], {idx, 1'b1}, {8'h00, 8'hA1 + 8'(k)});
      end
    end
  endtask

  task automatic test_count0();
    clear_log();
    start_cmd(9'h033, 10'd0);
    wait_idle("count0");
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (wr_adr_q.size() !== 0) begin n_fail++; $display("FAIL count0_writes: got %0d want 0", wr_adr_q.size()); end
    n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL count0_in_ready: high %0d cycles want 0", ready_seen); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL count0_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc - s_cyc < 1 || done_cyc - s_cyc > 2) begin n_fail++; $display("FAIL count0_done_cycle: rel %0d want 1..2", done_cyc - s_cyc); end
  endtask

  task automatic test_full();
    int bad = 0;
    clear_log();
    start_cmd(9'd0, 10'd512);
    for (int i = 0; i < 512; i++) feed({8'(i) ^ 8'h5A, 16'(i * 3 + 1)}, 0);
    wait_idle("full");
    for (int i = 0; i < 512; i++) begin
      if (wr_adr_q[2*i] !== {9'(i), 1'b0} || wr_dat_q[2*i] !== 16'(i * 3 + 1) ||
          wr_adr_q[2*i+1] !== {9'(i), 1'b1} || wr_dat_q[2*i+1] !== {8'h00, 8'(i) ^ 8'h5A}) bad++;
    end
    n_checks++; if (wr_adr_q.size() !== 1024) begin n_fail++; $display("FAIL full_nwrites: got %0d want 1024", wr_adr_q.size()); end
    n_checks++; if (wr_adr_q[1023] !== 10'h3FF) begin n_fail++; $display("FAIL full_last_adr: got %h want 3ff", wr_adr_q[1023]); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_content: %0d bad entries want 0", bad); end
    n_checks++; if (wr_cyc_q[2] - wr_cyc_q[0] !== 3) begin n_fail++; $display("FAIL full_throughput: %0d cycles/entry want 3", wr_cyc_q[2] - wr_cyc_q[0]); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [23:0] beats [3];
    beats[0] = 24'h123456; beats[1] = 24'h789ABC; beats[2] = 24'hDEF012;
    clear_log();
    start_cmd(9'd100, 10'd3);
    for (int k = 0; k < 3; k++) feed(beats[k], 5);
    wait_idle("bp");
    n_checks++; if (we_in_fetch !== 0) begin n_fail++; $display("FAIL bp_write_in_fetch: %0d cycles want 0", we_in_fetch); end
    n_checks++; if (acc_cyc_q.size() !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d want 3", acc_cyc_q.size()); end
    n_checks++; if (wr_adr_q.size() !== 6) begin n_fail++; $display("FAIL bp_nwrites: got %0d want 6", wr_adr_q.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wr_adr_q[2*k] !== {9'(100 + k), 1'b0} || wr_dat_q[2*k] !== beats[k][15:0] ||
          wr_adr_q[2*k+1] !== {9'(100 + k), 1'b1} || wr_dat_q[2*k+1] !== {8'h00, beats[k][23:16]}) begin
        n_fail++; $display("FAIL bp_entry_%0d: got %h/%h %h/%h", k, wr_adr_q[2*k], wr_dat_q[2*k], wr_adr_q[2*k+1], wr_dat_q[2*k+1]);
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    clear_log();
    start_cmd(9'd20, 10'd3);
    feed(24'h123456, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if (pal_we !== 1'b1 || pal_adr !== 10'h029 || pal_dat !== 16'h0012) begin n_fail++; $display("FAIL abort_hi_write: we=%b adr=%h dat=%h want 1/029/0012", pal_we, pal_adr, pal_dat); end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
    n_checks++; if (wr_adr_q.size() !== 2) begin n_fail++; $display("FAIL abort_nwrites: got %0d want 2", wr_adr_q.size()); end
    n_checks++; if (pal_adr !== 10'h029 || pal_dat !== 16'h0012) begin n_fail++; $display("FAIL abort_hold: adr=%h dat=%h want 029/0012", pal_adr, pal_dat); end
  endtask

  task automatic test_reset_mid();
    start_cmd(9'd7, 10'd2);
    #2; rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: ready=%b busy=%b done=%b want 0", in_ready, busy, done); end
    n_checks++; if (pal_we !== 1'b0 || pal_adr !== 10'h000 || pal_dat !== 16'h0000) begin n_fail++; $display("FAIL rstmid_bus: we=%b adr=%h dat=%h want 0", pal_we, pal_adr, pal_dat); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

`ifdef PALWR_VBLANK_GATE_EN
  task automatic test_gate();
    clear_log();
    start_cmd(9'd40, 10'd1);
    vblank = 1'b0;
    feed(24'h00BEEF, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (pal_we !== 1'b0) begin n_fail++; $display("FAIL gate_stall_%0d: pal_we=%b want 0", i, pal_we); end
    end
    vblank = 1'b1;
    @(negedge clk);
    n_checks++; if (pal_we !== 1'b1 || pal_adr !== 10'h050 || pal_dat !== 16'hBEEF) begin n_fail++; $display("FAIL gate_lo: we=%b adr=%h dat=%h want 1/050/beef", pal_we, pal_adr, pal_dat); end
    @(negedge clk);
    n_checks++; if (pal_we !== 1'b1 || pal_adr !== 10'h051 || pal_dat !== 16'h0000) begin n_fail++; $display("FAIL gate_hi: we=%b adr=%h dat=%h want 1/051/0000", pal_we, pal_adr, pal_dat); end
    wait_idle("gate");
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL gate_done: got %0d want 1", done_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_log();
    test_reset();
`ifdef PALWR_VBLANK_GATE_EN
    test_single(9'd5, 24'hAABBCC, 1'b1);
`else
    test_single(9'd5, 24'hAABBCC, 1'b0);
`endif
    test_wrap();
    test_count0();
    test_backpressure();
    test_abort();
    test_full();
`ifdef PALWR_VBLANK_GATE_EN
    test_gate();
`endif
    test_reset_mid();
    test_single(9'd300, 24'hC0FFEE, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
